// File: rtl/ccd_frame_sequencer.sv
// ----------------------------------------------------------------------------
// ccd_frame_sequencer
//
// Timing controller for the linear CCD front end of the sugar-detector
// spectrometer. It produces the CCD master clock (CCD_M), the shift gate
// (CCD_SH) and the integration clear gate (CCD_ICG). It sequences one
// charge-transfer/readout frame per trigger, or free-runs with a programmable
// integration period. During readout it emits a mid-slot ADC sample strobe
// together with the index of the pixel being sampled.
//
// Ports:
//   Master_clk  in   system clock (50 MHz)
//   rst         in   asynchronous, active-high reset
//   start       in   single-cycle frame trigger, honoured only in IDLE
//   cont        in   continuous mode, sampled at the end of READOUT
//   int_time    in   integration period in Master_clk cycles,
//                    latched at each CCD_ICG fall
//   CCD_M       out  CCD master clock, free-running
//   CCD_SH      out  shift gate, active high
//   CCD_ICG     out  integration clear gate, idle high, active low
//   adc_strobe  out  one-cycle pulse per pixel, mid-slot
//   pix_idx     out  index of the pixel being strobed, 0..PIXELS-1
//   busy        out  high whenever a frame is in progress
//   frame_done  out  one-cycle pulse in the last cycle of READOUT
// ----------------------------------------------------------------------------
module ccd_frame_sequencer #(
    parameter int FM_DIV   = 25,
    parameter int PIXELS   = 3694,
    parameter int PIX_DIV  = 200,
    parameter int SH_WIDTH = 100,
    parameter int ICG_LEAD = 25,
    parameter int ICG_LAG  = 50,
    parameter int INT_W    = 24
) (
    input  logic             Master_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [INT_W-1:0] int_time,
    output logic             CCD_M,
    output logic             CCD_SH,
    output logic             CCD_ICG,
    output logic             adc_strobe,
    output logic [11:0]      pix_idx,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SH,
        LAG,
        READOUT,
        WAIT
    } state_t;

    // The step counter times every phase. LAG can overrun its minimum by up
    // to one full CCD_M period while waiting for a rising edge, so its span
    // includes that slack and the counter never wraps inside a phase.
    localparam int FM_W   = (FM_DIV > 1) ? $clog2(FM_DIV) : 1;
    localparam int SPAN_A = (PIX_DIV > SH_WIDTH) ? PIX_DIV : SH_WIDTH;
    localparam int SPAN_B = (ICG_LEAD > ICG_LAG + 2 * FM_DIV) ? ICG_LEAD
                                                              : ICG_LAG + 2 * FM_DIV;
    localparam int SPAN   = (SPAN_A > SPAN_B) ? SPAN_A : SPAN_B;
    localparam int STEP_W = $clog2(SPAN + 1);

    localparam logic [FM_W-1:0]   FM_LAST   = FM_W'(FM_DIV - 1);
    localparam logic [STEP_W-1:0] LEAD_LAST = STEP_W'(ICG_LEAD - 1);
    localparam logic [STEP_W-1:0] SH_LAST   = STEP_W'(SH_WIDTH - 1);
    localparam logic [STEP_W-1:0] LAG_LAST  = STEP_W'(ICG_LAG - 1);
    localparam logic [STEP_W-1:0] SLOT_LAST = STEP_W'(PIX_DIV - 1);
    localparam logic [STEP_W-1:0] STROBE_AT = STEP_W'(PIX_DIV / 2 - 1);
    localparam logic [11:0]       PIX_LAST  = 12'(PIXELS - 1);

    state_t              state;
    state_t              state_next;
    logic [FM_W-1:0]     fm_cnt;
    logic                m_rise;
    logic [STEP_W-1:0]   step_cnt;
    logic                step_clr;
    logic                enter_lead;
    logic [INT_W-1:0]    period_cnt;
    logic [INT_W-1:0]    latched_int;
    logic [INT_W:0]      period_plus1;
    logic                period_met;
    logic                sh_next;
    logic                icg_next;

    // m_rise marks the cycle at whose end CCD_M goes from 0 to 1, so any
    // register updated on that same edge switches together with CCD_M.
    assign m_rise = (fm_cnt == FM_LAST) && !CCD_M;

    // The integration period is met once the cycles elapsed since the last
    // ICG fall, counting the current one, reach the latched period. The
    // extra bit keeps a saturated counter and a zero period well defined.
    // The same test decides both the WAIT exit and the direct jump from
    // READOUT to LEAD when the frame already outlasted the period.
    assign period_plus1 = {1'b0, period_cnt} + {{INT_W{1'b0}}, 1'b1};
    assign period_met   = period_plus1 >= {1'b0, latched_int};

    // The gate pins are registered from the next state so that they switch
    // on exactly the edge where the sequencer changes phase.
    assign sh_next  = (state_next == SH);
    assign icg_next = !((state_next == LEAD) || (state_next == SH) ||
                        (state_next == LAG));

    // CCD master clock divider. It runs from reset release and is never
    // gated, so the sensor always sees a steady fM.
    always_ff @(posedge Master_clk or posedge rst) begin
        if (rst) begin
            fm_cnt <= '0;
            CCD_M  <= 1'b0;
        end else if (fm_cnt == FM_LAST) begin
            fm_cnt <= '0;
            CCD_M  <= ~CCD_M;
        end else begin
            fm_cnt <= fm_cnt + 1'b1;
        end
    end

    // State register for the frame sequencer.
    always_ff @(posedge Master_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decoding. Each timed phase ends when the step
    // counter reaches its last value. LAG additionally waits for a CCD_M
    // rising edge, so the ICG rise always lines up with fM. In READOUT the
    // step counter serves as the pixel-slot counter. The strobe sits in the
    // middle of the slot and frame_done sits in the final slot cycle, so the
    // two can never be high together.
    always_comb begin
        state_next = state;
        step_clr   = 1'b0;
        enter_lead = 1'b0;
        adc_strobe = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LEAD;
                    enter_lead = 1'b1;
                end
            end
            LEAD: begin
                if (step_cnt == LEAD_LAST) begin
                    state_next = SH;
                    step_clr   = 1'b1;
                end
            end
            SH: begin
                if (step_cnt == SH_LAST) begin
                    state_next = LAG;
                    step_clr   = 1'b1;
                end
            end
            LAG: begin
                if ((step_cnt >= LAG_LAST) && m_rise) begin
                    state_next = READOUT;
                    step_clr   = 1'b1;
                end
            end
            READOUT: begin
                adc_strobe = (step_cnt == STROBE_AT);
                if (step_cnt == SLOT_LAST) begin
                    step_clr = 1'b1;
                    if (pix_idx == PIX_LAST) begin
                        frame_done = 1'b1;
                        if (!cont) begin
                            state_next = IDLE;
                        end else if (period_met) begin
                            state_next = LEAD;
                            enter_lead = 1'b1;
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (period_met) begin
                    state_next = LEAD;
                    enter_lead = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Phase/slot step counter. It restarts on every phase change and slot
    // wrap, and is held at zero while idle or waiting out the integration
    // period, so every timed phase begins counting from zero.
    always_ff @(posedge Master_clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (step_clr || (state == IDLE) || (state == WAIT)) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // Pixel index. It advances at each slot wrap and returns to zero after
    // the last pixel, ready for the next frame.
    always_ff @(posedge Master_clk or posedge rst) begin
        if (rst) begin
            pix_idx <= '0;
        end else if ((state == READOUT) && (step_cnt == SLOT_LAST)) begin
            if (pix_idx == PIX_LAST) begin
                pix_idx <= '0;
            end else begin
                pix_idx <= pix_idx + 1'b1;
            end
        end
    end

    // Integration bookkeeping. Every ICG fall restarts the period counter
    // and captures a fresh int_time. The counter saturates instead of
    // wrapping, so a very long idle spell can never fake a short period.
    always_ff @(posedge Master_clk or posedge rst) begin
        if (rst) begin
            period_cnt  <= '0;
            latched_int <= '0;
        end else if (enter_lead) begin
            period_cnt  <= '0;
            latched_int <= int_time;
        end else if (period_cnt != {INT_W{1'b1}}) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Registered gate pins, clean of decode glitches. ICG idles high.
    always_ff @(posedge Master_clk or posedge rst) begin
        if (rst) begin
            CCD_SH  <= 1'b0;
            CCD_ICG <= 1'b1;
        end else begin
            CCD_SH  <= sh_next;
            CCD_ICG <= icg_next;
        end
    end

endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ccd_frame_sequencer
//
// Self-checking bench for ccd_frame_sequencer with small parameters
// (8 pixels, 8-cycle slots, fM period of 4 cycles). Stimulus tasks push the
// expected pixel indices, frame completions and ICG fall-to-fall periods into
// queues. A negedge monitor pops and compares those entries as the DUT
// produces strobes, frame_done pulses and gate edges. It also checks the
// fixed gate timing relationships.
// ----------------------------------------------------------------------------
module tb_ccd_frame_sequencer;

    localparam int FM_DIV   = 2;
    localparam int PIXELS   = 8;
    localparam int PIX_DIV  = 8;
    localparam int SH_WIDTH = 6;
    localparam int ICG_LEAD = 3;
    localparam int ICG_LAG  = 4;
    localparam int INT_W    = 24;

    logic             Master_clk;
    logic             rst;
    logic             start;
    logic             cont;
    logic [INT_W-1:0] int_time;
    logic             CCD_M;
    logic             CCD_SH;
    logic             CCD_ICG;
    logic             adc_strobe;
    logic [11:0]      pix_idx;
    logic             busy;
    logic             frame_done;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int pix_q[$];
    int done_q[$];
    int gap_q[$];

    int fall_count    = 0;
    int done_count    = 0;
    int strobe_count  = 0;
    int sh_rise_count = 0;
    int last_fall     = -1;
    int last_done     = -1;
    int sh_rise_at    = 0;
    int sh_fall_at    = 0;
    int icg_rise_at   = 0;
    int last_strobe   = -1;
    int frame_strobes = 0;
    bit clamp_chk     = 1'b0;

    ccd_frame_sequencer #(
        .FM_DIV  (FM_DIV),
        .PIXELS  (PIXELS),
        .PIX_DIV (PIX_DIV),
        .SH_WIDTH(SH_WIDTH),
        .ICG_LEAD(ICG_LEAD),
        .ICG_LAG (ICG_LAG),
        .INT_W   (INT_W)
    ) dut (
        .Master_clk(Master_clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .int_time  (int_time),
        .CCD_M     (CCD_M),
        .CCD_SH    (CCD_SH),
        .CCD_ICG   (CCD_ICG),
        .adc_strobe(adc_strobe),
        .pix_idx   (pix_idx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // 100 MHz bench clock. Only relative cycle counts matter.
    initial Master_clk = 1'b0;
    always #5 Master_clk = ~Master_clk;

    // Rising-edge cycle counter used to time every observed event.
    always @(posedge Master_clk) cycle <= cycle + 1;

    // Global watchdog so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Master_clk);
            #1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_CCD_M"}, CCD_M, 0);
        checkOutput({tag, "_CCD_SH"}, CCD_SH, 0);
        checkOutput({tag, "_CCD_ICG"}, CCD_ICG, 1);
        checkOutput({tag, "_adc_strobe"}, adc_strobe, 0);
        checkOutput({tag, "_pix_idx"}, pix_idx, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Bounded wait on one of the monitor event counters
    // (0 = ICG falls, 1 = frame_done, 2 = strobes, 3 = SH rises).
    task automatic waitEvent(input string tag, input int which, input int target,
                             input int max_cycles);
        int val;
        val = 0;
        for (int n = 0; n < max_cycles; n++) begin
            @(negedge Master_clk);
            #1;
            case (which)
                0:       val = fall_count;
                1:       val = done_count;
                2:       val = strobe_count;
                default: val = sh_rise_count;
            endcase
            if (val >= target) break;
        end
        checkOutput({tag, "_reached"}, (val >= target) ? 1 : 0, 1);
    endtask

    // Queues the expectations for a run of frames and fires one start pulse.
    task automatic applyStimulus(input bit use_cont, input int itime, input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int p = 0; p < PIXELS; p++) pix_q.push_back(p);
            done_q.push_back(PIXELS - 1);
        end
        cont      = use_cont;
        int_time  = INT_W'(itime);
        last_fall = -1;
        last_done = -1;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin
        logic prev_icg;
        logic prev_sh;
        logic prev_m;
        int   d;
        prev_icg = 1'b1;
        prev_sh  = 1'b0;
        prev_m   = 1'b0;
        forever begin
            @(negedge Master_clk);
            if (!rst) begin
                if (prev_icg && !CCD_ICG) begin
                    fall_count++;
                    if ((last_fall >= 0) && (gap_q.size() > 0))
                        checkOutput("icg_period", cycle - last_fall, gap_q.pop_front());
                    if (clamp_chk && (last_done >= 0))
                        checkOutput("clamp_fall", cycle - last_done, 1);
                    last_fall = cycle;
                end
                if (!prev_sh && CCD_SH) begin
                    sh_rise_count++;
                    checkOutput("sh_lead", cycle - last_fall, ICG_LEAD);
                    sh_rise_at = cycle;
                end
                if (prev_sh && !CCD_SH) begin
                    checkOutput("sh_width", cycle - sh_rise_at, SH_WIDTH);
                    sh_fall_at = cycle;
                end
                if (!prev_icg && CCD_ICG) begin
                    d = cycle - sh_fall_at;
                    checkOutput("icg_rise_win", ((d >= 4) && (d <= 7)) ? 1 : 0, 1);
                    checkOutput("icg_m_align", (CCD_M && !prev_m) ? 1 : 0, 1);
                    icg_rise_at   = cycle;
                    last_strobe   = -1;
                    frame_strobes = 0;
                end
                if (adc_strobe) begin
                    strobe_count++;
                    frame_strobes++;
                    checkOutput("strobe_vs_done", frame_done, 0);
                    if (last_strobe < 0)
                        checkOutput("strobe_phase", cycle - icg_rise_at, PIX_DIV / 2 - 1);
                    else
                        checkOutput("strobe_gap", cycle - last_strobe, PIX_DIV);
                    last_strobe = cycle;
                    checkOutput("strobe_queued", (pix_q.size() > 0) ? 1 : 0, 1);
                    if (pix_q.size() > 0)
                        checkOutput("pix_idx", pix_idx, pix_q.pop_front());
                end
                if (frame_done) begin
                    done_count++;
                    checkOutput("done_time", cycle - icg_rise_at, PIXELS * PIX_DIV - 1);
                    checkOutput("frame_strobes", frame_strobes, PIXELS);
                    checkOutput("done_queued", (done_q.size() > 0) ? 1 : 0, 1);
                    if (done_q.size() > 0)
                        checkOutput("done_pix", pix_idx, done_q.pop_front());
                    last_done = cycle;
                end
            end
            prev_icg = CCD_ICG;
            prev_sh  = CCD_SH;
            prev_m   = CCD_M;
        end
    end

    initial begin
        int base_f;
        int base_d;
        int base_s;
        int r1;
        int r2;
        logic pm;

        rst      = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        int_time = '0;
        tick(3);
        checkResetOutputs("por");
        rst = 1'b0;
        tick(5);

        // Single frame.
        base_d = done_count;
        applyStimulus(1'b0, 0, 1);
        waitEvent("t1_done", 1, base_d + 1, 300);
        tick(1);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_icg_idle", CCD_ICG, 1);
        checkOutput("t1_pix_left", pix_q.size(), 0);

        // Continuous mode with a long integration period: three frames.
        base_f = fall_count;
        base_d = done_count;
        gap_q.push_back(200);
        gap_q.push_back(200);
        applyStimulus(1'b1, 200, 3);
        waitEvent("t2_fall3", 0, base_f + 3, 700);
        cont = 1'b0;
        waitEvent("t2_done", 1, base_d + 3, 400);
        tick(2);
        checkOutput("t2_busy", busy, 0);
        checkOutput("t2_gap_left", gap_q.size(), 0);
        checkOutput("t2_pix_left", pix_q.size(), 0);

        // Continuous mode, period shorter than a frame: no WAIT dwell.
        base_f    = fall_count;
        base_d    = done_count;
        clamp_chk = 1'b1;
        applyStimulus(1'b1, 10, 2);
        waitEvent("t3_fall2", 0, base_f + 2, 300);
        cont = 1'b0;
        waitEvent("t3_done", 1, base_d + 2, 300);
        clamp_chk = 1'b0;
        tick(2);
        checkOutput("t3_busy", busy, 0);
        checkOutput("t3_pix_left", pix_q.size(), 0);

        // start during READOUT is ignored; clearing cont in SH ends the run.
        base_f = fall_count;
        base_d = done_count;
        base_s = strobe_count;
        applyStimulus(1'b1, 200, 1);
        waitEvent("t4_sh", 3, sh_rise_count + 1, 50);
        cont = 1'b0;
        waitEvent("t4_strobe", 2, base_s + 3, 100);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        waitEvent("t4_done", 1, base_d + 1, 200);
        tick(60);
        checkOutput("t4_one_frame", fall_count - base_f, 1);
        checkOutput("t4_one_done", done_count - base_d, 1);
        checkOutput("t4_busy", busy, 0);

        // Reset in the middle of READOUT at pixel 4.
        base_d = done_count;
        base_s = strobe_count;
        applyStimulus(1'b0, 0, 1);
        waitEvent("t5_strobe", 2, base_s + 5, 200);
        checkOutput("t5_pix_before", pix_idx, 4);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_rst");
        pix_q.delete();
        done_q.delete();
        tick(3);
        rst = 1'b0;
        r1 = -1;
        r2 = -1;
        pm = CCD_M;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (CCD_M && !pm) begin
                if (r1 < 0) r1 = cycle;
                else if (r2 < 0) r2 = cycle;
            end
            pm = CCD_M;
        end
        checkOutput("m_period", r2 - r1, 2 * FM_DIV);
        checkOutput("t5_no_done", done_count - base_d, 0);
        applyStimulus(1'b0, 0, 1);
        waitEvent("t5_done", 1, base_d + 1, 300);
        tick(1);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_pix_left", pix_q.size(), 0);
        checkOutput("t5_done_left", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_frame_sequencer.md
Name: ccd_frame_sequencer

Overview:
- Timing controller for the linear CCD front end of the sugar-detector spectrometer.
- Generates CCD_M (fM), CCD_SH and CCD_ICG from Master_clk.
- Sequences one charge-transfer/readout frame per trigger, or free-runs with a programmable integration period.
- Emits a per-pixel ADC sample strobe with a pixel index, feeding the capture/ADC block downstream.

Parameters:
- FM_DIV, 25: Master_clk cycles per half-period of CCD_M (50 MHz gives 1 MHz fM).
- PIXELS, 3694: pixel slots read per frame.
- PIX_DIV, 200: Master_clk cycles per pixel slot; must be a multiple of 2*FM_DIV.
- SH_WIDTH, 100: Master_clk cycles CCD_SH is held high.
- ICG_LEAD, 25: cycles from CCD_ICG fall to CCD_SH rise.
- ICG_LAG, 50: minimum cycles from CCD_SH fall to CCD_ICG rise.
- INT_W, 24: width of int_time.

Ports:
- Master_clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous and active-high. Clock and reset are named as the codebase does, one clock; polarity and synchronicity are fixed.
- start  in  1  single-cycle frame trigger; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at end of READOUT.
- int_time  in  INT_W  integration period in Master_clk cycles; latched at each CCD_ICG fall.
- CCD_M  out  1  CCD master clock.
- CCD_SH  out  1  shift gate, active high.
- CCD_ICG  out  1  integration clear gate; idle high, active low.
- adc_strobe  out  1  one-cycle pulse per pixel, mid-slot.
- pix_idx  out  12  index of the pixel being strobed, 0..PIXELS-1.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse at the end of READOUT.

Behaviour:
- Reset values: CCD_M=0, CCD_SH=0, CCD_ICG=1, adc_strobe=0, pix_idx=0, busy=0, frame_done=0. State is IDLE; all counters are 0.
- Reset mid-frame: all outputs return immediately to their reset values; no partial frame_done is produced.
- CCD_M:
  - Free-runs from reset release and is never gated.
  - Toggles when its divider reaches FM_DIV-1.
  - m_rise is the internal flag for the cycle where CCD_M goes 0 to 1.
- State IDLE: on start=1, go to LEAD. CCD_ICG falls in that same transition. The period counter clears and int_time is latched.
- State LEAD: hold ICG_LEAD cycles, then CCD_SH goes high and the state moves to SH.
- State SH: hold SH_WIDTH cycles, then CCD_SH goes low and the state moves to LAG.
- State LAG:
  - Wait at least ICG_LAG cycles, then continue waiting for the next m_rise.
  - On that cycle CCD_ICG goes high, the pixel-slot counter clears, and the state moves to READOUT.
  - The ICG rise is therefore always coincident with a CCD_M rising edge.
- State READOUT:
  - The slot counter runs 0..PIX_DIV-1.
  - adc_strobe is high for the single cycle where slot==PIX_DIV/2-1, with pix_idx equal to the current pixel.
  - pix_idx increments at slot wrap.
  - After pixel PIXELS-1's slot ends, frame_done pulses for 1 cycle and pix_idx returns to 0.
  - Next state: cont=1 goes to WAIT, otherwise IDLE.
- State WAIT: when the period counter is at least latched_int-1, go to LEAD. This re-latches int_time and lowers CCD_ICG.
- Integration clamp: if latched int_time is not larger than the elapsed frame length, LEAD is entered on the cycle after READOUT ends.
- Period counter:
  - Counts Master_clk cycles since the last CCD_ICG fall.
  - Saturates at all-ones and never wraps.
- Mode-change and trigger rules:
  - Clearing cont mid-frame completes the current frame, then goes to IDLE.
  - start while busy is ignored and never queued.
  - start and the cycle of reset release are independent; start is honoured only while rst=0.
- frame_done and adc_strobe can never be high in the same cycle.
- CCD_SH is high only in SH; CCD_ICG is low only in LEAD, SH and LAG.

Test Plan:
- Reset: assert rst mid-stream -> all outputs equal their reset values in the same cycle, and CCD_M resumes toggling after release with period 2*FM_DIV.
- Single frame with PIXELS=8, PIX_DIV=8, FM_DIV=2, SH_WIDTH=6, ICG_LEAD=3, ICG_LAG=4, cont=0, start pulse:
  - CCD_ICG low, then 3 cycles later CCD_SH high for exactly 6 cycles.
  - CCD_ICG rises 4-7 cycles after SH falls, coincident with a CCD_M rise.
  - 8 adc_strobe pulses spaced 8 cycles apart, pix_idx 0..7.
  - One frame_done pulse, then busy=0.
- Continuous, long integration: same params, cont=1, int_time=200 -> consecutive CCD_ICG falls are exactly 200 cycles apart over 3 frames.
- Continuous, clamped: int_time=10 -> next CCD_ICG fall occurs on the cycle after frame_done, with no WAIT dwell.
- start pulsed during READOUT -> no effect; exactly one frame is produced. Clearing cont during SH -> that frame completes, then IDLE.
- rst during READOUT at pix_idx=4 -> no frame_done. A subsequent start produces a full 8-pixel frame starting at pix_idx=0.
